// File: rtl/fsmc_bus_if.sv
// FSMC multiplexed-bus front end: synchronises the async strobes and AD bus, latches
// address/data and emits one-cycle downstream write/read strobes.
module fsmc_bus_if #(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        FSMC_NE,
   input  logic        FSMC_NADV,
   input  logic        FSMC_NWE,
   input  logic        FSMC_NOE,
   input  logic [15:0] FSMC_AD_I,
   output logic [15:0] FSMC_AD_O,
   output logic        FSMC_AD_OE,
   input  logic [15:0] RD_DATA,
   output logic        CS,
   output logic        WR_EN,
   output logic        RD_EN,
   output logic [15:0] ADDR,
   output logic [15:0] DATA,
   output logic        BUS_ERR
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      IDLE, ADDR_WAIT, ACTIVE, WR_STB, RD_STB, RD_DRIVE, DONE
   } state_t;

   logic [SYNC_STAGES-1:0]       ne_sy, nadv_sy, nwe_sy, noe_sy;
   logic [SYNC_STAGES-1:0][15:0] ad_sy;
   logic                         ne_d, nadv_d, nwe_d, noe_d;
   logic                         ne_s, nadv_s, nwe_s, noe_s;
   logic [15:0]                  ad_s;
   logic                         ne_rise, ne_fall, nadv_rise, nwe_rise, noe_fall;
   state_t                       state;
   logic [CW-1:0]                cnt;

   // Strobes reset to their inactive (high) level so no edge is seen on reset release.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         ne_sy   <= '1;
         nadv_sy <= '1;
         nwe_sy  <= '1;
         noe_sy  <= '1;
         ad_sy   <= '0;
         ne_d    <= 1'b1;
         nadv_d  <= 1'b1;
         nwe_d   <= 1'b1;
         noe_d   <= 1'b1;
      end else begin
         ne_sy   <= {ne_sy[SYNC_STAGES-2:0], FSMC_NE};
         nadv_sy <= {nadv_sy[SYNC_STAGES-2:0], FSMC_NADV};
         nwe_sy  <= {nwe_sy[SYNC_STAGES-2:0], FSMC_NWE};
         noe_sy  <= {noe_sy[SYNC_STAGES-2:0], FSMC_NOE};
         ad_sy   <= {ad_sy[SYNC_STAGES-2:0], FSMC_AD_I};
         ne_d    <= ne_s;
         nadv_d  <= nadv_s;
         nwe_d   <= nwe_s;
         noe_d   <= noe_s;
      end
   end

   assign ne_s      = ne_sy[SYNC_STAGES-1];
   assign nadv_s    = nadv_sy[SYNC_STAGES-1];
   assign nwe_s     = nwe_sy[SYNC_STAGES-1];
   assign noe_s     = noe_sy[SYNC_STAGES-1];
   assign ad_s      = ad_sy[SYNC_STAGES-1];
   assign ne_rise   = ne_s & ~ne_d;
   assign ne_fall   = ~ne_s & ne_d;
   assign nadv_rise = nadv_s & ~nadv_d;
   assign nwe_rise  = nwe_s & ~nwe_d;
   assign noe_fall  = ~noe_s & noe_d;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state      <= IDLE;
         cnt        <= '0;
         CS         <= 1'b1;
         WR_EN      <= 1'b0;
         RD_EN      <= 1'b0;
         ADDR       <= '0;
         DATA       <= '0;
         FSMC_AD_O  <= '0;
         FSMC_AD_OE <= 1'b0;
         BUS_ERR    <= 1'b0;
      end else begin
         CS      <= 1'b1;
         WR_EN   <= 1'b0;
         RD_EN   <= 1'b0;
         BUS_ERR <= 1'b0;
         // Counter saturates at the limit so a stuck bus reports only once.
         if (state == IDLE)
            cnt <= '0;
         else if (cnt != CW'(TIMEOUT_CYC))
            cnt <= cnt + 1'b1;

         case (state)
            IDLE:
               if (ne_fall) state <= ADDR_WAIT;
            ADDR_WAIT:
               if (ne_rise) state <= IDLE;
               else if (nadv_rise) begin
                  ADDR  <= ad_s;
                  state <= ACTIVE;
               end
            ACTIVE:
               // A write edge coinciding with NE release is still committed.
               if (nwe_rise) begin
                  DATA  <= ad_s;
                  state <= WR_STB;
               end else if (ne_rise) state <= IDLE;
               else if (nadv_rise) ADDR <= ad_s;
               else if (noe_fall) state <= RD_STB;
            WR_STB: begin
               CS    <= 1'b0;
               WR_EN <= 1'b1;
               state <= ne_s ? IDLE : DONE;
            end
            RD_STB: begin
               CS    <= 1'b0;
               RD_EN <= 1'b1;
               state <= ne_rise ? IDLE : RD_DRIVE;
            end
            RD_DRIVE:
               if (ne_rise || noe_s) begin
                  FSMC_AD_OE <= 1'b0;
                  state      <= ne_rise ? IDLE : DONE;
               end else if (RD_EN) begin
                  // RD_EN is high only during the first RD_DRIVE cycle: capture once.
                  FSMC_AD_O  <= RD_DATA;
                  FSMC_AD_OE <= 1'b1;
               end
            DONE:
               if (ne_s) state <= IDLE;
               else if (nadv_rise) begin
                  ADDR  <= ad_s;
                  state <= ACTIVE;
               end
            default: state <= IDLE;
         endcase

         if (state != IDLE && cnt == CW'(TIMEOUT_CYC - 1)) begin
            BUS_ERR    <= 1'b1;
            FSMC_AD_OE <= 1'b0;
            CS         <= 1'b1;
            WR_EN      <= 1'b0;
            RD_EN      <= 1'b0;
            state      <= DONE;
         end
      end
   end

endmodule

// File: tb/tb_fsmc_bus_if.sv
// Bench for fsmc_bus_if: directed vector table, corner sequences and randomized
// transactions checked against a transaction-level scoreboard.
module tb_fsmc_bus_if;

   localparam int S = 2;

   logic clk = 1'b0, rst_n = 1'b0;
   logic ne = 1'b1, nadv = 1'b1, nwe = 1'b1, noe = 1'b1;
   logic [15:0] ad_i = '0;
   logic [15:0] rd_data, ad_o, addr, data;
   logic ad_oe, cs, wr_en, rd_en, bus_err;
   logic [15:0] to_rd_data, to_ad_o, to_addr, to_data;
   logic to_ad_oe, to_cs, to_wr_en, to_rd_en, to_bus_err;

   int checks = 0, fails = 0, cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Downstream read mux: content is a fixed function of the address.
   function automatic logic [15:0] rd_fn(input logic [15:0] a);
      return a ^ 16'h1224;
   endfunction
   assign rd_data    = rd_fn(addr);
   assign to_rd_data = rd_fn(to_addr);

   fsmc_bus_if #(.SYNC_STAGES(S), .TIMEOUT_CYC(255)) u_dut (
      .CLK(clk), .RST_N(rst_n), .FSMC_NE(ne), .FSMC_NADV(nadv), .FSMC_NWE(nwe),
      .FSMC_NOE(noe), .FSMC_AD_I(ad_i), .FSMC_AD_O(ad_o), .FSMC_AD_OE(ad_oe),
      .RD_DATA(rd_data), .CS(cs), .WR_EN(wr_en), .RD_EN(rd_en), .ADDR(addr),
      .DATA(data), .BUS_ERR(bus_err));

   fsmc_bus_if #(.SYNC_STAGES(S), .TIMEOUT_CYC(16)) u_to (
      .CLK(clk), .RST_N(rst_n), .FSMC_NE(ne), .FSMC_NADV(nadv), .FSMC_NWE(nwe),
      .FSMC_NOE(noe), .FSMC_AD_I(ad_i), .FSMC_AD_O(to_ad_o), .FSMC_AD_OE(to_ad_oe),
      .RD_DATA(to_rd_data), .CS(to_cs), .WR_EN(to_wr_en), .RD_EN(to_rd_en),
      .ADDR(to_addr), .DATA(to_data), .BUS_ERR(to_bus_err));

   typedef struct {
      logic        rd;
      logic [15:0] addr;
      logic [15:0] word;
   } ev_t;

   typedef struct {
      logic        rd;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic        keep;
      logic [15:0] exp_word;
   } vec_t;

   ev_t obs_q[$];
   ev_t exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Output monitor: records strobes as events and checks ADDR/DATA stability around writes.
   logic [15:0] prv_addr = '0, prv_data = '0, sav_addr = '0, sav_data = '0;
   logic prv_oe = 1'b0, chk_after = 1'b0;
   int wr_cnt = 0, rd_cnt = 0, last_wr_cyc = 0, last_rd_cyc = 0, last_oe_cyc = 0;
   int err_cnt = 0, to_err_cnt = 0, to_err_cyc = 0, to_wr_cnt = 0;

   always begin
      @(posedge clk);
      #1;
      chk("cs_vs_strobe", {31'b0, cs}, {31'b0, ~(wr_en | rd_en)});
      if (wr_en) begin
         wr_cnt++;
         last_wr_cyc = cyc;
         obs_q.push_back('{1'b0, addr, data});
         chk("addr_pre_pulse", {16'b0, addr}, {16'b0, prv_addr});
         chk("data_pre_pulse", {16'b0, data}, {16'b0, prv_data});
         chk_after = 1'b1;
         sav_addr  = addr;
         sav_data  = data;
      end else if (chk_after) begin
         chk("addr_post_pulse", {16'b0, addr}, {16'b0, sav_addr});
         chk("data_post_pulse", {16'b0, data}, {16'b0, sav_data});
         chk_after = 1'b0;
      end
      if (rd_en) begin
         rd_cnt++;
         last_rd_cyc = cyc;
      end
      if (ad_oe && !prv_oe) begin
         last_oe_cyc = cyc;
         obs_q.push_back('{1'b1, addr, ad_o});
      end
      if (bus_err) err_cnt++;
      if (to_bus_err) begin
         to_err_cnt++;
         to_err_cyc = cyc;
      end
      if (to_wr_en) to_wr_cnt++;
      prv_addr = addr;
      prv_data = data;
      prv_oe   = ad_oe;
   end

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One bus access with legal firmware timing; e0 = first edge sampling the NWE rise / NOE fall.
   task automatic do_txn(input logic rd, input logic [15:0] a, input logic [15:0] w,
                         input logic keep, input int lo, output int e0);
      @(negedge clk);
      ne = 1'b0; nadv = 1'b0; ad_i = a;
      wait_n(lo);
      nadv = 1'b1;
      wait_n(1);
      if (!rd) begin
         ad_i = w; nwe = 1'b0;
         wait_n(lo);
         nwe = 1'b1; e0 = cyc + 1;
         wait_n(1);
         ad_i = 16'($urandom);
      end else begin
         ad_i = 16'($urandom); noe = 1'b0; e0 = cyc + 1;
         wait_n(lo + 2);
         noe = 1'b1;
         wait_n(1);
      end
      if (!keep) ne = 1'b1;
      wait_n(3);
   endtask

   task automatic pop_chk(input string name, input ev_t exp);
      ev_t ev;
      checks++;
      if (obs_q.size() == 0) begin
         fails++;
         $display("FAIL %s actual=no_event required=addr %h word %h", name, exp.addr, exp.word);
      end else begin
         checks--;
         ev = obs_q.pop_front();
         chk({name, "_kind"}, {31'b0, ev.rd}, {31'b0, exp.rd});
         chk({name, "_addr"}, {16'b0, ev.addr}, {16'b0, exp.addr});
         chk({name, "_word"}, {16'b0, ev.word}, {16'b0, exp.word});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl[4];
      int e0, wr0, rd0, chain;
      ev_t ev;

      tbl[0] = '{1'b0, 16'h0001, 16'hA5C3, 1'b0, 16'hA5C3};
      tbl[1] = '{1'b1, 16'h0010, 16'h0000, 1'b0, 16'h1234};
      tbl[2] = '{1'b0, 16'h0001, 16'h0001, 1'b1, 16'h0001};
      tbl[3] = '{1'b0, 16'h0002, 16'hBEEF, 1'b0, 16'hBEEF};

      wait_n(4);
      chk("rst_cs", {31'b0, cs}, 32'd1);
      chk("rst_strobes", {29'b0, wr_en, rd_en, bus_err}, 32'd0);
      chk("rst_addr_data", {addr, data}, 32'd0);
      chk("rst_ad", {15'b0, ad_oe, ad_o}, 32'd0);
      rst_n = 1'b1;
      wait_n(4);

      // Directed vectors
      for (int i = 0; i < 4; i++) begin
         wr0 = wr_cnt; rd0 = rd_cnt;
         do_txn(tbl[i].rd, tbl[i].addr, tbl[i].wdata, tbl[i].keep, S + 4, e0);
         pop_chk($sformatf("vec%0d", i), '{tbl[i].rd, tbl[i].addr, tbl[i].exp_word});
         if (!tbl[i].rd) begin
            chk($sformatf("vec%0d_wr_cyc", i), 32'(last_wr_cyc), 32'(e0 + S + 1));
            chk($sformatf("vec%0d_wr_cnt", i), 32'(wr_cnt - wr0), 32'd1);
            chk($sformatf("vec%0d_no_rd", i), 32'(rd_cnt - rd0), 32'd0);
         end else begin
            chk($sformatf("vec%0d_rd_cyc", i), 32'(last_rd_cyc), 32'(e0 + S + 1));
            chk($sformatf("vec%0d_oe_cyc", i), 32'(last_oe_cyc), 32'(e0 + S + 2));
            chk($sformatf("vec%0d_rd_cnt", i), 32'(rd_cnt - rd0), 32'd1);
            chk($sformatf("vec%0d_oe_off", i), {31'b0, ad_oe}, 32'd0);
         end
      end

      // NWE pulse without address phase, then a sub-cycle glitch in ACTIVE: no strobe
      wr0 = wr_cnt; rd0 = rd_cnt;
      @(negedge clk);
      ne = 1'b0; nadv = 1'b0; ad_i = 16'h0077;
      wait_n(6);
      nwe = 1'b0;
      wait_n(6);
      nwe = 1'b1;
      wait_n(2);
      nadv = 1'b1;
      wait_n(3);
      #1 nwe = 1'b0;
      #2 nwe = 1'b1;
      wait_n(5);
      ne = 1'b1;
      wait_n(5);
      chk("glitch_no_wr", 32'(wr_cnt - wr0), 32'd0);
      chk("glitch_no_rd", 32'(rd_cnt - rd0), 32'd0);
      chk("glitch_no_event", 32'(obs_q.size()), 32'd0);

      // Timeout on the 16-cycle instance
      to_err_cnt = 0; to_wr_cnt = 0; wr0 = wr_cnt;
      @(negedge clk);
      ne = 1'b0; nadv = 1'b0; ad_i = 16'h0033; e0 = cyc + 1;
      wait_n(6);
      nadv = 1'b1;
      wait_n(30);
      ne = 1'b1;
      wait_n(5);
      chk("to_err_cnt", 32'(to_err_cnt), 32'd1);
      chk("to_err_cyc", 32'(to_err_cyc), 32'(e0 + S + 16));
      chk("to_no_wr", 32'(to_wr_cnt), 32'd0);
      chk("to_main_no_wr", 32'(wr_cnt - wr0), 32'd0);

      // Reset during RD_DRIVE
      @(negedge clk);
      ne = 1'b0; nadv = 1'b0; ad_i = 16'h0040;
      wait_n(6);
      nadv = 1'b1;
      wait_n(1);
      noe = 1'b0;
      for (int i = 0; i < 20 && !ad_oe; i++) @(negedge clk);
      chk("mid_read_oe", {31'b0, ad_oe}, 32'd1);
      pop_chk("mid_read", '{1'b1, 16'h0040, rd_fn(16'h0040)});
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("rrst_oe_cs", {30'b0, ad_oe, cs}, 32'd1);
      chk("rrst_strobes", {29'b0, wr_en, rd_en, bus_err}, 32'd0);
      chk("rrst_addr_data", {addr, data}, 32'd0);
      chk("rrst_ad_o", {16'b0, ad_o}, 32'd0);
      ne = 1'b1; nadv = 1'b1; noe = 1'b1;
      wait_n(4);
      rst_n = 1'b1;
      wait_n(4);

      // Randomized transactions against the scoreboard
      chain = 0;
      for (int i = 0; i < 24; i++) begin
         logic rd, keep;
         logic [15:0] a, w;
         rd   = 1'($urandom);
         a    = 16'($urandom);
         w    = 16'($urandom);
         keep = (i != 23) && (chain < 3) && 1'($urandom);
         chain = keep ? chain + 1 : 0;
         exp_q.push_back('{rd, a, rd ? rd_fn(a) : w});
         do_txn(rd, a, w, keep, S + 4 + int'($urandom_range(0, 2)), e0);
      end
      wait_n(4);
      chk("rand_event_count", 32'(obs_q.size()), 32'(exp_q.size()));
      while (exp_q.size() > 0) begin
         ev = exp_q.pop_front();
         pop_chk("rand", ev);
      end

      chk("main_no_bus_err", 32'(err_cnt), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/fsmc_bus_if.md
# fsmc_bus_if

Clocked front end for the STM32 FSMC multiplexed parallel bus. It synchronises the asynchronous NE/NADV/NWE/NOE strobes and the AD bus into the FPGA clock domain. It latches the address phase and turns each bus write into a one-cycle, glitch-free CS/WR_EN strobe with stable ADDR/DATA for the downstream bus-addressed control and parameter registers. For bus reads it issues a one-cycle RD_EN and drives the read-back word onto AD.

## Interface
- SYNC_STAGES, 2: synchroniser depth for all FSMC inputs; minimum 2.
- TIMEOUT_CYC, 255: CLK cycles allowed from leaving IDLE until NE deasserts; exceeding it is a bus error.
- CLK  in  1  system clock; single clock domain.
- RST_N  in  1  reset, synchronous, active-low.
- FSMC_NE  in  1  chip enable, async, active-low.
- FSMC_NADV  in  1  address valid, async, active-low; address is taken on its rising edge.
- FSMC_NWE  in  1  write strobe, async, active-low; data is taken on its rising edge.
- FSMC_NOE  in  1  read strobe, async, active-low.
- FSMC_AD_I  in  16  AD pad input.
- FSMC_AD_O  out  16  AD pad output data.
- FSMC_AD_OE  out  1  AD pad output enable; the tristate buffer lives at top level.
- RD_DATA  in  16  read-back word from the downstream read mux; must be valid one cycle after RD_EN.
- CS  out  1  downstream chip select, active-low.
- WR_EN  out  1  downstream write enable, active-high.
- RD_EN  out  1  downstream read strobe, active-high.
- ADDR  out  16  latched bus address.
- DATA  out  16  latched write data.
- BUS_ERR  out  1  one-cycle pulse on timeout.

## Operation
- **Synchronisers.** NE, NADV, NWE and NOE pass through SYNC_STAGES flops each. AD_I passes through an equal-depth delay line so the data word stays aligned with the strobes. Edge detect compares the last stage with one extra registered stage.
- **FSM states.**
  - IDLE: NE_s falling -> ADDR_WAIT.
  - ADDR_WAIT: NADV_s rising -> ADDR <= aligned AD, go to ACTIVE.
  - ACTIVE:
    - NWE_s rising -> DATA <= aligned AD, go to WR_STB.
    - NOE_s falling -> RD_STB.
  - WR_STB: CS=0 and WR_EN=1 for exactly one cycle, then DONE.
  - RD_STB: CS=0 and RD_EN=1 for exactly one cycle, then RD_DRIVE.
  - RD_DRIVE: on entry, FSMC_AD_O <= RD_DATA and FSMC_AD_OE=1. Hold both until NOE_s rising, then DONE.
  - DONE: wait for NE_s high.
- **NE rising.** NE_s rising in any non-IDLE state -> IDLE. FSMC_AD_OE drops on the same edge.
- **Re-latch.** NADV_s rising in ACTIVE or DONE re-latches ADDR and goes to ACTIVE, supporting back-to-back accesses without NE toggle.
- **Ignored strobes.** NWE/NOE edges outside ACTIVE are ignored; no strobe is issued.
- **Output stability.** ADDR and DATA change only on the latch edges above. Both are stable for at least one cycle before and after the CS/WR_EN pulse, so level-sensitive consumers see no glitch. CS, WR_EN and RD_EN are registered outputs.
- **Timeout.** Counter width is clog2(TIMEOUT_CYC+1). It clears in IDLE and increments in every other state. On reaching TIMEOUT_CYC: one BUS_ERR pulse, FSMC_AD_OE=0, go to DONE.
- **Simultaneous events.**
  - NWE_s rising and NE_s rising detected in the same cycle: the write is still committed (WR_STB, then IDLE).
  - Reset during any state wins: all outputs return to reset values on the next edge.
- **Reset values.** CS=1, WR_EN=0, RD_EN=0, ADDR=0, DATA=0, FSMC_AD_O=0, FSMC_AD_OE=0, BUS_ERR=0, state IDLE, counter 0.

## Timing
- **Reference edge.** E0 is the first CLK edge that samples the new pin level.
- **Write.** Pin NWE rising at E0 -> CS=0/WR_EN=1 registered from E0+SYNC_STAGES+1 for one cycle. DATA is valid from E0+SYNC_STAGES.
- **Read.** Pin NOE falling at E0 -> RD_EN from E0+SYNC_STAGES+1 for one cycle. FSMC_AD_OE/FSMC_AD_O are valid from E0+SYNC_STAGES+2.
- **Firmware constraint.** FSMC timing must meet both of the following:
  - NWE and NOE low, and NADV high before data, each ≥ SYNC_STAGES+4 CLK periods.
  - AD held ≥ 1 CLK period after NWE rising.
- **Pulse width.** Maximum strobe rate is one access per 2·SYNC_STAGES+6 cycles.

## Test plan
- Write ADDR=0x0001 DATA=0xA5C3, SYNC_STAGES=2:
  - exactly one cycle of CS=0 & WR_EN=1, 3 edges after the NWE rise is sampled;
  - ADDR=0x0001 and DATA=0xA5C3 are stable ±1 cycle around the pulse;
  - no RD_EN.
- Read ADDR=0x0010 with RD_DATA=0x1234 -> one RD_EN pulse; FSMC_AD_O=0x1234 with FSMC_AD_OE=1 until NOE rises; OE=0 afterwards.
- Two back-to-back writes (0x0001/0x0001, then 0x0002/0xBEEF) with NE held low -> two WR_EN pulses with the correct ADDR/DATA pairing.
- NE low, NADV toggled, NWE never asserted, TIMEOUT_CYC=16 -> BUS_ERR pulse exactly 16 cycles after leaving IDLE; no WR_EN.
- NWE pulse with no NADV, plus a 1-cycle glitch on NWE shorter than the synchroniser -> no strobe output.
- RST_N low mid-read (during RD_DRIVE) -> on the next edge FSMC_AD_OE=0, CS=1, and all outputs equal their reset values.
